// File: rtl/id_pkg.sv
// Shared decode constants and control-word layout for the ID stage.
// The opcode decoder lives here so the bench-facing top stays datapath-only.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int EX_ALUSRC    = 3;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_REGDST    = 0;
  localparam int MEM_WRITE    = 1;
  localparam int MEM_READ     = 0;
  localparam int WB_MEMTOREG  = 1;
  localparam int WB_REGWRITE  = 0;

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.ex[EX_ALUOP_LSB +: 2] = ALUOP_FUNCT;
        c.ex[EX_REGDST]         = 1'b1;
        c.wb[WB_REGWRITE]       = 1'b1;
      end
      OP_LW: begin
        c.ex[EX_ALUSRC]         = 1'b1;
        c.ex[EX_ALUOP_LSB +: 2] = ALUOP_ADD;
        c.mem[MEM_READ]         = 1'b1;
        c.wb[WB_MEMTOREG]       = 1'b1;
        c.wb[WB_REGWRITE]       = 1'b1;
      end
      OP_SW: begin
        c.ex[EX_ALUSRC]         = 1'b1;
        c.mem[MEM_WRITE]        = 1'b1;
      end
      OP_ADDI: begin
        c.ex[EX_ALUSRC]         = 1'b1;
        c.wb[WB_REGWRITE]       = 1'b1;
      end
      OP_BEQ, OP_BNE: c.ex[EX_ALUOP_LSB +: 2] = ALUOP_SUB;
      OP_J:           c = '0;
      default:        c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_wf.sv
// Two-read / one-write register file; a read of the register being written
// this cycle returns the write data. Register 0 is hard-wired to zero.
module regfile_wf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : (wr_ok && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (wr_ok && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: register file, decoder, in-ID branch resolution,
// hazard detection and the ID/EX pipeline register with bubble insertion.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       In_PC,
  input  logic [31:0]       In_IR,
  input  logic              In_Hold,
  input  logic [REG_AW-1:0] In_Rd,
  input  logic [DATA_W-1:0] In_WriteData,
  input  logic              In_RegWrite,
  input  logic [REG_AW-1:0] In_MemRd,
  input  logic [DATA_W-1:0] In_MemData,
  input  logic              In_MemRegWrite,
  output logic              Out_Stall,
  output logic              Out_PCSrc,
  output logic [31:0]       Out_BranchPC,
  output logic [DATA_W-1:0] Out_DataA,
  output logic [DATA_W-1:0] Out_DataB,
  output logic [DATA_W-1:0] Out_SE,
  output logic [5:0]        Out_Funct,
  output logic [REG_AW-1:0] Out_Rs,
  output logic [REG_AW-1:0] Out_Rt,
  output logic [REG_AW-1:0] Out_Rd,
  output logic [3:0]        Out_EXControl,
  output logic [1:0]        Out_MEMControl,
  output logic [1:0]        Out_WBControl,
  output logic              Out_Illegal
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b, se;
  ctrl_t             dec;
  logic              is_beq, is_bne, is_j, is_br, uses_rt;
  logic              fwd_a, fwd_b;
  logic [REG_AW-1:0] idex_dest;
  logic              hz_load, hz_branch, hz_nofwd;
  logic [31:0]       br_target, jmp_target;

  assign opcode = In_IR[31:26];
  assign rs     = In_IR[21 +: REG_AW];
  assign rt     = In_IR[16 +: REG_AW];
  assign rd     = In_IR[11 +: REG_AW];
  assign se     = {{(DATA_W-16){In_IR[15]}}, In_IR[15:0]};
  assign dec    = decode_op(opcode);

  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_j    = (opcode == OP_J);
  assign is_br   = is_beq || is_bne;
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_br;

  regfile_wf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk (Clk),
    .rst (Rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_a),
    .rd2 (rf_b),
    .wa  (In_Rd),
    .wd  (In_WriteData),
    .we  (In_RegWrite)
  );

  // Comparator operands take the MEM result when it targets a source register.
  assign fwd_a = (FWD_EN != 0) && In_MemRegWrite && (In_MemRd == rs) && (rs != '0);
  assign fwd_b = (FWD_EN != 0) && In_MemRegWrite && (In_MemRd == rt) && (rt != '0);
  assign op_a  = fwd_a ? In_MemData : rf_a;
  assign op_b  = fwd_b ? In_MemData : rf_b;

  assign idex_dest = Out_EXControl[EX_REGDST] ? Out_Rd : Out_Rt;

  assign hz_load   = Out_MEMControl[MEM_READ] && (Out_Rt != '0) &&
                     ((Out_Rt == rs) || (uses_rt && (Out_Rt == rt)));
  assign hz_branch = is_br && Out_WBControl[WB_REGWRITE] && (idex_dest != '0) &&
                     ((idex_dest == rs) || (idex_dest == rt));
  assign hz_nofwd  = (FWD_EN == 0) && is_br && In_MemRegWrite && (In_MemRd != '0) &&
                     ((In_MemRd == rs) || (In_MemRd == rt));

  assign Out_Stall = In_Hold || hz_load || hz_branch || hz_nofwd;

  assign br_target    = In_PC + {{14{In_IR[15]}}, In_IR[15:0], 2'b00};
  assign jmp_target   = {In_PC[31:28], In_IR[25:0], 2'b00};
  assign Out_BranchPC = is_j ? jmp_target : br_target;
  assign Out_PCSrc    = !Out_Stall &&
                        (is_j || (is_beq && (op_a == op_b)) || (is_bne && (op_a != op_b)));

  always_ff @(posedge Clk) begin
    if (Rst || (!In_Hold && Out_Stall)) begin
      Out_DataA      <= '0;
      Out_DataB      <= '0;
      Out_SE         <= '0;
      Out_Funct      <= '0;
      Out_Rs         <= '0;
      Out_Rt         <= '0;
      Out_Rd         <= '0;
      Out_EXControl  <= '0;
      Out_MEMControl <= '0;
      Out_WBControl  <= '0;
      Out_Illegal    <= 1'b0;
    end else if (!In_Hold) begin
      Out_DataA      <= rf_a;
      Out_DataB      <= rf_b;
      Out_SE         <= se;
      Out_Funct      <= In_IR[5:0];
      Out_Rs         <= rs;
      Out_Rt         <= rt;
      Out_Rd         <= rd;
      Out_EXControl  <= dec.ex;
      Out_MEMControl <= dec.mem;
      Out_WBControl  <= dec.wb;
      Out_Illegal    <= dec.illegal;
    end
  end

endmodule
